// File: rtl/record_packer.sv
// record_packer: buffers 47-bit tagger records in a FIFO and streams each out
// as six LSB-first bytes, tagging records that follow a drop.
module record_packer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  record_rdy,
    input  logic [46:0]           record,
    input  logic                  clear_lost,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [7:0]            lost_count,
    output logic                  lost_pending
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;
    logic [47:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [47:0] shreg;
    logic [2:0] idx;
    logic full, store, drop, pop, hs;

    // Full uses the count from the start of the cycle, so a same-cycle pop never frees a slot.
    assign full  = fifo_count == (DEPTH_LOG2+1)'(DEPTH);
    assign store = record_rdy && !full;
    assign drop  = record_rdy && full;
    assign pop   = state == IDLE && fifo_count != '0;
    assign hs    = out_valid && out_ready;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;

    always_comb
        state_next = (state == IDLE) ? (pop ? SEND : IDLE) : ((hs && idx == 3'd5) ? IDLE : SEND);

    always_comb begin
        out_valid = state == SEND;
        out_data  = out_valid ? shreg[7:0] : 8'd0;
    end

    always_ff @(posedge clk)
        if (store && !reset) mem[wr_ptr] <= {lost_pending, record};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            shreg        <= '0;
            idx          <= '0;
            lost_count   <= '0;
            lost_pending <= 1'b0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                shreg  <= mem[rd_ptr];
                idx    <= '0;
                rd_ptr <= rd_ptr + 1'b1;
            end else if (hs) begin
                shreg <= shreg >> 8;
                idx   <= idx + 3'd1;
            end
            fifo_count   <= fifo_count + (DEPTH_LOG2+1)'(store) - (DEPTH_LOG2+1)'(pop);
            lost_count   <= clear_lost ? {7'd0, drop} : (drop && lost_count != 8'hFF) ? lost_count + 8'd1 : lost_count;
            lost_pending <= !clear_lost && (drop || (lost_pending && !store));
        end
    end
endmodule

// File: tb/tb_record_packer.sv
// tb_record_packer: cycle-level queue model of the packer plus directed literal checks.
module tb_record_packer;
    logic clk = 1'b0, reset = 1'b1, record_rdy = 1'b0, clear_lost = 1'b0, out_ready = 1'b0;
    logic [46:0] record = '0;
    logic [7:0] out_data, lost_count;
    logic out_valid, lost_pending;
    logic [4:0] fifo_count;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    record_packer #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .record_rdy(record_rdy), .record(record),
        .clear_lost(clear_lost), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .lost_count(lost_count),
        .lost_pending(lost_pending)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a record queue plus the record being sent and which byte is on the wire.
    logic [47:0] q[$];
    logic [47:0] cur = '0;
    bit sending = 0;
    int bi = 0, m_cnt = 0;
    bit m_pend = 0;

    always @(posedge clk) begin
        int pre;
        bit drp;
        if (reset) begin
            q.delete();
            sending = 0;
            bi = 0;
            m_cnt = 0;
            m_pend = 0;
        end else begin
            pre = q.size();
            if (!sending && pre != 0) begin
                cur = q.pop_front();
                sending = 1;
                bi = 0;
            end else if (sending && out_ready) begin
                if (bi == 5) sending = 0;
                else bi++;
            end
            drp = record_rdy && pre == 16;
            if (record_rdy && !drp) begin
                q.push_back({m_pend, record});
                m_pend = 0;
            end
            if (clear_lost) begin
                m_cnt = drp ? 1 : 0;
                m_pend = 0;
            end else if (drp) begin
                m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
                m_pend = 1;
            end
        end
    end

    logic [7:0] blog[$];

    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", out_valid, sending);
            check("out_data", out_data, sending ? cur[8*bi +: 8] : 8'h00);
            check("fifo_count", fifo_count, q.size());
            check("lost_count", lost_count, m_cnt);
            check("lost_pending", lost_pending, m_pend);
            if (out_valid && out_ready) blog.push_back(out_data);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [46:0] r);
        record = r;
        record_rdy = 1'b1;
        tick();
        record_rdy = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((fifo_count != 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        check(nm, n < 500, 1'b1);
    endtask

    function automatic logic [47:0] rec_at(input int r);
        logic [47:0] w;
        for (int b = 0; b < 6; b++) w[8*b +: 8] = blog[6*r + b];
        return w;
    endfunction

    logic [7:0] exp_bytes[6] = '{8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'h3C};

    initial begin
        tick(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_count", fifo_count, 5'd0);
        check("rst_lost", lost_count, 8'd0);
        check("rst_pend", lost_pending, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        // Single record: latency and byte order.
        blog.delete();
        strobe(47'h3CDE_F012_3456);
        check("lat_n_valid", out_valid, 1'b0);
        check("lat_n_count", fifo_count, 5'd1);
        tick();
        check("lat_n1_valid", out_valid, 1'b1);
        check("lat_n1_data", out_data, 8'h56);
        check("lat_n1_count", fifo_count, 5'd0);
        tick(10);
        check("single_len", blog.size(), 6);
        for (int i = 0; i < 6; i++) check("single_byte", blog[i], exp_bytes[i]);
        // Backpressure with ready pattern 1,0,0,1.
        blog.delete();
        strobe(47'h3CDE_F012_3456);
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_len", blog.size(), 6);
        for (int i = 0; i < 6; i++) check("bp_byte", blog[i], exp_bytes[i]);
        // Overflow: record 1 is popped into the sender, 2..17 fill the FIFO, 18..20 drop.
        blog.delete();
        out_ready = 1'b0;
        record_rdy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            record = 47'(k);
            tick();
        end
        record_rdy = 1'b0;
        check("ovf_count", fifo_count, 5'd16);
        check("ovf_lost", lost_count, 8'd3);
        check("ovf_pend", lost_pending, 1'b1);
        strobe(47'd21);
        check("ovf21_lost", lost_count, 8'd4);
        out_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_len", blog.size(), 17 * 6);
        if (blog.size() == 17 * 6)
            for (int r = 0; r < 17; r++) check("ovf_rec", rec_at(r), 48'(r + 1));
        // Lost flag on the first record stored after the drops.
        blog.delete();
        strobe(47'd22);
        check("flag_pend", lost_pending, 1'b0);
        check("flag_lost", lost_count, 8'd4);
        tick(10);
        check("flag_len", blog.size(), 6);
        if (blog.size() == 6) begin
            check("flag_b0", blog[0], 8'd22);
            check("flag_b5", blog[5], 8'h80);
        end
        // Saturation and clear.
        out_ready = 1'b0;
        record_rdy = 1'b1;
        for (int i = 0; i < 320; i++) begin
            record = 47'({$urandom, $urandom});
            tick();
        end
        record_rdy = 1'b0;
        check("sat_lost", lost_count, 8'd255);
        check("sat_pend", lost_pending, 1'b1);
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        check("clr_lost", lost_count, 8'd0);
        check("clr_pend", lost_pending, 1'b0);
        clear_lost = 1'b1;
        strobe(47'h1);
        clear_lost = 1'b0;
        check("clrdrop_lost", lost_count, 8'd1);
        check("clrdrop_pend", lost_pending, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 600; i++) begin
            record_rdy = ($urandom % 3) == 0;
            record = 47'({$urandom, $urandom});
            out_ready = ($urandom % 4) != 0;
            clear_lost = ($urandom % 50) == 0;
            tick();
        end
        record_rdy = 1'b0;
        clear_lost = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        // Reset after the byte-2 handshake.
        blog.delete();
        strobe(47'h7FFF_0000_FFFF);
        for (int n = 0; n < 20 && blog.size() < 3; n++) tick();
        check("mid_progress", blog.size(), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", out_valid, 1'b0);
        check("mid_count", fifo_count, 5'd0);
        blog.delete();
        strobe(47'h1234_5678_9ABC);
        tick(10);
        check("post_len", blog.size(), 6);
        if (blog.size() == 6) begin
            check("post_b0", blog[0], 8'hBC);
            check("post_b5", blog[5], 8'h12);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
